// File: rtl/fpaddsub_execute_stage.sv
// FP add/subtract execute stage: two-stage pipelined magnitude add/sub, sign, zero flag and LZC.
// Optional macro FPADDSUB_EXEC_ZERO_FLUSH_EN: a zero result is emitted as +0 with exponent 0.
module fpaddsub_execute_stage #(
    parameter int unsigned LZC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Op,
    input  logic             Sa,
    input  logic             Sb,
    input  logic             MaxAB,
    input  logic [7:0]       Es,
    input  logic [24:0]      Mmax,
    input  logic [49:0]      Mmin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [49:0]      Sum,
    output logic [LZC_W-1:0] Lzc,
    output logic             Sign,
    output logic             Zero,
    output logic [7:0]       Eout
);

    logic             v1_q, v2_q;
    logic             adv1, adv2;
    logic [49:0]      s1_q;
    logic             sign1_q;
    logic [7:0]       e1_q;
    logic [49:0]      sum_q;
    logic [LZC_W-1:0] lzc_q;
    logic             sign_q, zero_q;
    logic [7:0]       eout_q;

    logic [49:0]      x_op, y_op, s1_d;
    logic             eff_sub, sign1_d;
    logic [LZC_W-1:0] lzc_d;
    logic             zero_d, sign2_d;
    logic [7:0]       e2_d;

    // Mmax[24] and Mmin[49] are don't-care inputs.
    logic unused_bits;
    assign unused_bits = ^{Mmax[24], Mmin[49]};

    assign adv2     = ~v2_q | out_ready;
    assign adv1     = ~v1_q | adv2;
    assign in_ready = adv1;

    always_comb begin
        x_op    = {1'b0, Mmax[23:0], 25'b0};
        y_op    = {1'b0, Mmin[48:0]};
        eff_sub = Sa ^ Sb ^ Op;
        // X >= Y is guaranteed upstream, so the subtraction never borrows.
        s1_d    = eff_sub ? (x_op - y_op) : (x_op + y_op);
        sign1_d = MaxAB ? Sa : (Sb ^ Op);
    end

    always_comb begin
        lzc_d = LZC_W'(50);
        for (int i = 0; i < 50; i++) begin
            if (s1_q[i]) lzc_d = LZC_W'(49 - i);
        end
        zero_d = (s1_q == 50'd0);
`ifdef FPADDSUB_EXEC_ZERO_FLUSH_EN
        sign2_d = zero_d ? 1'b0 : sign1_q;
        e2_d    = zero_d ? 8'h00 : e1_q;
`else
        sign2_d = sign1_q;
        e2_d    = e1_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            sign1_q <= 1'b0;
            e1_q    <= '0;
        end else if (adv1) begin
            v1_q    <= in_valid;
            s1_q    <= s1_d;
            sign1_q <= sign1_d;
            e1_q    <= Es;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            sum_q  <= '0;
            lzc_q  <= '0;
            sign_q <= 1'b0;
            zero_q <= 1'b0;
            eout_q <= '0;
        end else if (adv2) begin
            v2_q   <= v1_q;
            sum_q  <= s1_q;
            lzc_q  <= lzc_d;
            sign_q <= sign2_d;
            zero_q <= zero_d;
            eout_q <= e2_d;
        end
    end

    assign out_valid = v2_q;
    assign Sum       = sum_q;
    assign Lzc       = lzc_q;
    assign Sign      = sign_q;
    assign Zero      = zero_q;
    assign Eout      = eout_q;

endmodule

// File: tb/tb_fpaddsub_execute_stage.sv
// Self-checking bench for fpaddsub_execute_stage: queue-based reference model plus directed cases.
module tb_fpaddsub_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic        Op, Sa, Sb, MaxAB;
    logic [7:0]  Es, Eout;
    logic [24:0] Mmax;
    logic [49:0] Mmin, Sum;
    logic [5:0]  Lzc;
    logic        Sign, Zero;

    fpaddsub_execute_stage #(.LZC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Op(Op), .Sa(Sa), .Sb(Sb), .MaxAB(MaxAB), .Es(Es), .Mmax(Mmax), .Mmin(Mmin),
        .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Lzc(Lzc),
        .Sign(Sign), .Zero(Zero), .Eout(Eout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [49:0] sum;
        logic [5:0]  lzc;
        logic        sign;
        logic        zero;
        logic [7:0]  e;
        int          edge_n;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic op, input logic sa, input logic sb,
                                   input logic maxab, input logic [7:0] es,
                                   input logic [24:0] mmax, input logic [49:0] mmin);
        exp_t r;
        longint unsigned x, y, s;
        x = longint'(mmax[23:0]) * (64'd1 << 25);
        y = longint'(mmin[48:0]);
        s = (sa ^ sb ^ op) ? x - y : x + y;
        r.sum  = s[49:0];
        r.zero = (s == 0);
        r.lzc  = 6'd50;
        for (int i = 49; i >= 0; i--) begin
            if (r.sum[i]) begin
                r.lzc = 6'(49 - i);
                break;
            end
        end
        r.sign = maxab ? sa : (sb ^ op);
        r.e    = es;
`ifdef FPADDSUB_EXEC_ZERO_FLUSH_EN
        if (r.zero) begin
            r.sign = 1'b0;
            r.e    = 8'h00;
        end
`endif
        r.edge_n = 0;
        return r;
    endfunction

    // Compare process: every falling edge, outputs checked against the model queue.
    always @(negedge clk) begin
        logic exp_ov;
        exp_t m;
        if (!rst_n) begin
            q.delete();
            chk("reset out_valid", 64'(out_valid), 64'd0);
            chk("reset Sum", 64'(Sum), 64'd0);
            chk("reset Eout_Lzc_Sign_Zero", 64'({Eout, Lzc, Sign, Zero}), 64'd0);
            chk("reset in_ready", 64'(in_ready), 64'd1);
        end else begin
            // The oldest item is at the output once it has spent one edge in stage 1.
            exp_ov = (q.size() > 0) && (cyc >= q[0].edge_n + 1);
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            chk("in_ready", 64'(in_ready), 64'(!(q.size() >= 2 && !out_ready)));
            if (out_valid && exp_ov) begin
                chk("Sum", 64'(Sum), 64'(q[0].sum));
                chk("Lzc", 64'(Lzc), 64'(q[0].lzc));
                chk("Sign", 64'(Sign), 64'(q[0].sign));
                chk("Zero", 64'(Zero), 64'(q[0].zero));
                chk("Eout", 64'(Eout), 64'(q[0].e));
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                m = model(Op, Sa, Sb, MaxAB, Es, Mmax, Mmin);
                m.edge_n = cyc + 1;
                q.push_back(m);
                n_acc++;
            end
        end
    end

    task automatic set_rand();
        longint unsigned x, y;
        Op    = 1'($urandom);
        Sa    = 1'($urandom);
        Sb    = 1'($urandom);
        MaxAB = 1'($urandom);
        Es    = 8'($urandom);
        Mmax  = 25'($urandom);
        if ($urandom_range(3) != 0) Mmax[23] = 1'b1;
        x = longint'(Mmax[23:0]) * (64'd1 << 25);
        y = {32'($urandom), 32'($urandom)} & ((64'd1 << 49) - 1);
        case ($urandom_range(7))
            0:       y = x;
            1:       y = 0;
            default: y = y % (x + 1);
        endcase
        Mmin = {1'($urandom), y[48:0]};
    endtask

    task automatic directed(input string nm, input logic op, input logic sa, input logic sb,
                            input logic maxab, input logic [7:0] es, input logic [24:0] mmax,
                            input logic [49:0] mmin, input logic [49:0] e_sum,
                            input logic [5:0] e_lzc, input logic e_sign, input logic e_zero,
                            input logic [7:0] e_e);
        int k;
        @(posedge clk); #1;
        Op = op; Sa = sa; Sb = sb; MaxAB = maxab; Es = es; Mmax = mmax; Mmin = mmin;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({nm, " accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        chk({nm, " latency"}, 64'(k), 64'd2);
        chk({nm, " Sum"}, 64'(Sum), 64'(e_sum));
        chk({nm, " Lzc"}, 64'(Lzc), 64'(e_lzc));
        chk({nm, " Sign"}, 64'(Sign), 64'(e_sign));
        chk({nm, " Zero"}, 64'(Zero), 64'(e_zero));
        chk({nm, " Eout"}, 64'(Eout), 64'(e_e));
    endtask

    initial begin
        exp_t pin;
        logic [49:0] one_al;
        logic [7:0]  zero_e;
        int budget;
        one_al = 50'h0800000 << 25;
`ifdef FPADDSUB_EXEC_ZERO_FLUSH_EN
        zero_e = 8'h00;
`else
        zero_e = 8'h7F;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Op = 0; Sa = 0; Sb = 0; MaxAB = 0; Es = 0; Mmax = 0; Mmin = 0;

        pin = model(1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 25'h0800000, one_al);
        chk("model pin 1+1", 64'(pin.sum), 64'h2000000000000);
        pin = model(1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 25'h0800000, 50'h800000000000);
        chk("model pin 1+0.5 lzc", 64'(pin.lzc), 64'd1);

        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        directed("1+1", 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 25'h0800000, one_al,
                 50'h2000000000000, 6'd0, 1'b0, 1'b0, 8'h7F);
        directed("1-1", 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 25'h0800000, one_al,
                 50'h0, 6'd50, 1'b0, 1'b1, zero_e);
        directed("1+0.5", 1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 25'h0800000, 50'h800000000000,
                 50'h1800000000000, 6'd1, 1'b1, 1'b0, 8'h7F);

        // Backpressure: two accepted, third stalls until out_ready rises.
        repeat (3) @(posedge clk);
        #1; out_ready = 1'b0; in_valid = 1'b1; set_rand();
        @(negedge clk); chk("bp first in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; set_rand();
        @(negedge clk); chk("bp second in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; set_rand();
        @(negedge clk); chk("bp third in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1; set_rand();
        @(negedge clk); chk("bp still stalled", 64'(in_ready), 64'd0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); chk("bp third accepted", 64'(in_ready), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); chk("bp drained", 64'(q.size()), 64'd0);

        // Asynchronous reset with both stages full.
        @(posedge clk); #1; out_ready = 1'b0; in_valid = 1'b1; set_rand();
        @(posedge clk); #1; set_rand();
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk("pre-reset out_valid", 64'(out_valid), 64'd1);
        #2; rst_n = 1'b0; #1;
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        chk("async reset Sum", 64'(Sum), 64'd0);
        chk("async reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1;
        directed("post-reset 1+1", 1'b0, 1'b0, 1'b0, 1'b0, 8'h7F, 25'h0800000, one_al,
                 50'h2000000000000, 6'd0, 1'b0, 1'b0, 8'h7F);

        // Random streaming with toggling backpressure.
        n_acc = 0;
        budget = 0;
        while (n_acc < 200 && budget < 5000) begin
            @(posedge clk); #1;
            set_rand();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            budget++;
        end
        chk("stream completed", 64'(n_acc >= 200), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk); chk("stream drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
